// File: rtl/dataram_arbiter.sv
// Two-master arbiter for the single-port data RAM: one transaction per IDLE->SERVE pass,
// with sub-word stores done as read-modify-write and loads returned right-justified.
module dataram_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 17,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [1:0]            m0_size,
    input  logic [BUS_WIDTH-1:0]  m0_adr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [1:0]            m1_size,
    input  logic [BUS_WIDTH-1:0]  m1_adr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_memwrite,
    output logic [BUS_WIDTH-1:0]  ram_adr,
    output logic [DATA_WIDTH-1:0] ram_writedata,
    input  logic [DATA_WIDTH-1:0] ram_readdata,
    output logic                  busy
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t                state, state_nxt;
    logic                  last_grant;   // 0 = m0, 1 = m1
    logic                  gnt_id;
    logic                  lat_we;
    logic [1:0]            lat_size;
    logic [BUS_WIDTH-1:0]  lat_adr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BUS_WIDTH-1:0]  adr_hold;
    logic [DATA_WIDTH-1:0] wd_hold;

    logic                  elig0, elig1, pick_m1;
    logic                  misaligned;
    logic [BUS_WIDTH-1:0]  aligned_adr;
    logic [DATA_WIDTH-1:0] extracted, merged;

    // A master in its own ack cycle is not eligible, so a held req is not re-served.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;

    always_comb begin
        pick_m1 = elig1;
        if (elig0 && elig1) begin
            pick_m1 = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        end
    end

    assign aligned_adr = {lat_adr[BUS_WIDTH-1:2], 2'b00};
    assign misaligned  = ((lat_size == 2'b01) && lat_adr[0]) ||
                         (lat_size[1] && (lat_adr[1:0] != 2'b00));

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        extracted = '0;
        merged    = ram_readdata;
        case (lat_size)
            2'b00: begin
                case (lat_adr[1:0])
                    2'd0: begin extracted[7:0] = ram_readdata[31:24]; merged[31:24] = lat_wdata[7:0]; end
                    2'd1: begin extracted[7:0] = ram_readdata[23:16]; merged[23:16] = lat_wdata[7:0]; end
                    2'd2: begin extracted[7:0] = ram_readdata[15:8];  merged[15:8]  = lat_wdata[7:0]; end
                    default: begin extracted[7:0] = ram_readdata[7:0]; merged[7:0]  = lat_wdata[7:0]; end
                endcase
            end
            2'b01: begin
                if (lat_adr[1]) begin
                    extracted[15:0] = ram_readdata[15:0];
                    merged[15:0]    = lat_wdata[15:0];
                end else begin
                    extracted[15:0] = ram_readdata[31:16];
                    merged[31:16]   = lat_wdata[15:0];
                end
            end
            default: begin
                extracted = ram_readdata;
                merged    = lat_wdata;
            end
        endcase
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        ram_memwrite  = 1'b0;
        ram_adr       = adr_hold;
        ram_writedata = wd_hold;
        case (state)
            IDLE: begin
                if (elig0 || elig1) state_nxt = SERVE;
            end
            SERVE: begin
                state_nxt     = IDLE;
                busy          = 1'b1;
                ram_memwrite  = lat_we & ~misaligned;
                ram_adr       = aligned_adr;
                ram_writedata = merged;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_adr    <= '0;
            lat_wdata  <= '0;
            adr_hold   <= '0;
            wd_hold    <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            state  <= state_nxt;
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            if (state == IDLE && (elig0 || elig1)) begin
                gnt_id     <= pick_m1;
                last_grant <= pick_m1;
                lat_we     <= pick_m1 ? m1_we    : m0_we;
                lat_size   <= pick_m1 ? m1_size  : m0_size;
                lat_adr    <= pick_m1 ? m1_adr   : m0_adr;
                lat_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
            end
            if (state == SERVE) begin
                adr_hold <= aligned_adr;
                wd_hold  <= merged;
                if (gnt_id) begin
                    m1_ack   <= 1'b1;
                    m1_err   <= misaligned;
                    m1_rdata <= misaligned ? '0 : extracted;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_err   <= misaligned;
                    m0_rdata <= misaligned ? '0 : extracted;
                end
            end
        end
    end

endmodule
